mmu_result_drain: RTL and testbench
===================================

Name: mmu_result_drain

Overview:
Output-side collector for the weight-stationary systolic array. The array emits result column j exactly j cycles after column 0 of the same vector, with no backpressure. This block de-skews the columns into one aligned result vector and buffers vectors in a FIFO. It then presents them downstream on a valid/ready interface, with frame-end marking and overflow detection.

Parameters:
SIZE, 4, array dimension; number of result columns
ACC_WIDTH, 16, width of each accumulated result
DEPTH, 8, FIFO depth in aligned vectors (power of 2, >=2)
FRAME, 4, vectors per frame; sets out_last spacing

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  pulse aligned to column 0 of a new result vector
acc_in  input  ACC_WIDTH x SIZE  unpacked array [SIZE-1:0], raw skewed array outputs
out_valid  output  1  aligned vector available
out_ready  input  1  downstream accepts; pop when out_valid && out_ready
out_data  output  ACC_WIDTH x SIZE  unpacked array [SIZE-1:0], aligned result vector
out_last  output  1  high with the final vector of each frame
fifo_level  output  $clog2(DEPTH)+1  stored vector count
overflow  output  1  sticky; an aligned vector was dropped

Behaviour:
- Reset is asynchronous and active-high.
  - While reset is high: all delay lines, valid pipe, FIFO pointers and frame counter clear.
  - Outputs: out_valid=0, out_data=0, out_last=0, fifo_level=0, overflow=0.
  - Any partially de-skewed vector is discarded.
- De-skew:
  - Column j is delayed by SIZE-1-j registers; column SIZE-1 passes straight through.
  - in_valid passes through a SIZE-1 stage valid pipe.
  - If in_valid is high in cycle t, the aligned vector and the aligned valid are present in cycle t+SIZE-1.
- The block must accept a new in_valid every cycle. Vectors overlap in the delay lines and must not corrupt one another.
- FIFO write: the aligned vector is written at the end of cycle t+SIZE-1.
  - If the FIFO is empty, out_valid rises in cycle t+SIZE, giving a latency of SIZE cycles.
- out_data and out_last are driven from the FIFO head and are stable while out_valid && !out_ready.
- Data values are passed unmodified: no truncation, no sign handling.
- Full-FIFO write:
  - Full, no pop in the same cycle: the vector is dropped, overflow is set and held until reset, and fifo_level stays at DEPTH.
  - Full with a simultaneous pop: the write is accepted and the level stays at DEPTH.
- Empty-FIFO read: out_ready has no effect.
  - A same-cycle write into an empty FIFO is not visible until the next cycle; there is no fall-through.
- Level tracking: fifo_level changes by +1 (write only), -1 (pop only) or 0 (both or neither).
- Frame counter:
  - Counts pops from 0 to FRAME-1.
  - out_last = out_valid && (frame_cnt == FRAME-1).
  - The counter wraps to 0 on the pop of the last vector. Drops do not advance it.
- Pointers wrap modulo DEPTH.

Decomposition:
- Shared package mmu_pkg holds:
  - localparams SIZE_D=4, ACC_WIDTH_D=16.
  - typedef acc_t (logic [ACC_WIDTH-1:0]).
  - typedef acc_vec_t (acc_t [SIZE-1:0]), used for the FIFO payload.
- One sub-module, drain_fifo: a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Async active-high reset.
- Delay lines, valid pipe, frame counter and overflow logic stay in mmu_result_drain.

Test Plan:
1. Reset: assert reset mid-stream with 3 vectors in flight and 2 stored -> outputs immediately 0, level 0, overflow 0. After release, the first new vector emerges with no stale data.
2. Single vector, SIZE=4: in_valid at cycle 0, with acc_in[0]=10 at cycle 0, [1]=20 at cycle 1, [2]=30 at cycle 2, [3]=40 at cycle 3, out_ready=1 -> out_valid only in cycle 4 with out_data={10,20,30,40}, and out_last=0.
3. Back-to-back: 8 consecutive in_valid with vector k having column j = 100k+j, out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, in order, with out_last on vectors 3 and 7.
4. Backpressure: out_ready=0, push 9 vectors -> level reaches 8 and overflow=1 after the 9th. Then out_ready=1 -> exactly vectors 0..7 drain in order, and overflow stays 1.
5. Full with simultaneous push and pop: level 8, out_ready=1 in the same cycle an aligned vector arrives -> level stays 8, overflow stays 0, and the new vector is the last one drained.
6. Stall stability: out_valid=1, out_ready toggled 0,0,1 -> out_data and out_last are held for 2 cycles, and the frame counter advances only on the pop.

Source files
------------

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and default dimensions for the result drain
package mmu_pkg;

  localparam int SIZE_D      = 4;
  localparam int ACC_WIDTH_D = 16;

  typedef logic [ACC_WIDTH_D-1:0] acc_t;
  typedef acc_t [SIZE_D-1:0]      acc_vec_t;

endpackage

// File: rtl/drain_fifo.sv
// rtl/drain_fifo.sv - synchronous FIFO holding aligned result vectors
module drain_fifo
  import mmu_pkg::*;
#(
  parameter int WIDTH = $bits(acc_vec_t),
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/mmu_result_drain.sv
// rtl/mmu_result_drain.sv - de-skews systolic array result columns and queues aligned vectors
module mmu_result_drain
  import mmu_pkg::*;
#(
  parameter int SIZE      = SIZE_D,
  parameter int ACC_WIDTH = ACC_WIDTH_D,
  parameter int DEPTH     = 8,
  parameter int FRAME     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [ACC_WIDTH-1:0]   acc_in [SIZE-1:0],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data [SIZE-1:0],
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;

  logic [SIZE-1:0][ACC_WIDTH-1:0] aligned_vec;
  logic [SIZE-1:0][ACC_WIDTH-1:0] head_vec;
  logic [SIZE-2:0]                vpipe_q, vpipe_d;
  logic                           aligned_valid;
  logic                           fifo_full, fifo_empty;
  logic                           push, pop, drop;
  logic                           overflow_q, overflow_d;
  logic [FW-1:0]                  frame_cnt_q, frame_cnt_d;
  logic                           at_frame_end;

  // Column j arrives j cycles late, so it waits SIZE-1-j cycles to line up with the last column.
  for (genvar j = 0; j < SIZE; j++) begin : g_col
    localparam int D = SIZE - 1 - j;
    if (D == 0) begin : g_thru
      assign aligned_vec[j] = acc_in[j];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] dl_q [D];
      logic [ACC_WIDTH-1:0] dl_d [D];
      always_comb begin
        dl_d[0] = acc_in[j];
        for (int k = 1; k < D; k++) begin
          dl_d[k] = dl_q[k-1];
        end
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) begin
            dl_q[k] <= '0;
          end
        end else begin
          dl_q <= dl_d;
        end
      end
      assign aligned_vec[j] = dl_q[D-1];
    end
  end

  always_comb begin
    vpipe_d[0] = in_valid;
    for (int k = 1; k < SIZE - 1; k++) begin
      vpipe_d[k] = vpipe_q[k-1];
    end
  end
  assign aligned_valid = vpipe_q[SIZE-2];

  drain_fifo #(
    .WIDTH (SIZE * ACC_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (aligned_vec),
    .rdata (head_vec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign at_frame_end = (frame_cnt_q == FW'(FRAME - 1));

  always_comb begin
    pop         = out_ready && !fifo_empty;
    push        = aligned_valid && (!fifo_full || pop);
    drop        = aligned_valid && fifo_full && !pop;
    overflow_d  = overflow_q || drop;
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      frame_cnt_d = at_frame_end ? '0 : frame_cnt_q + 1'b1;
    end
  end

  always_comb begin
    out_valid = !fifo_empty;
    out_last  = !fifo_empty && at_frame_end;
    overflow  = overflow_q;
    for (int j = 0; j < SIZE; j++) begin
      out_data[j] = fifo_empty ? '0 : head_vec[j];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe_q     <= '0;
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vpipe_q     <= vpipe_d;
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_mmu_result_drain.sv
// tb/tb_mmu_result_drain.sv - directed self-checking bench for mmu_result_drain
module tb_mmu_result_drain;

  localparam int SIZE      = 4;
  localparam int ACC_WIDTH = 16;
  localparam int DEPTH     = 8;
  localparam int FRAME     = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [ACC_WIDTH-1:0]   acc_in [SIZE-1:0];
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   out_data [SIZE-1:0];
  logic                   out_last;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int hb [SIZE];
  int hs [SIZE];

  mmu_result_drain #(
    .SIZE      (SIZE),
    .ACC_WIDTH (ACC_WIDTH),
    .DEPTH     (DEPTH),
    .FRAME     (FRAME)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input int base, input int step);
    for (int j = 0; j < SIZE; j++) begin
      chk(tag, 32'(out_data[j]), 32'(base + step * j));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hist();
    for (int i = 0; i < SIZE; i++) begin
      hb[i] = -1;
      hs[i] = 0;
    end
  endtask

  // Drives one cycle of skewed columns: column j carries the vector started j cycles ago.
  task automatic cyc(input bit v, input int base, input int step);
    for (int i = SIZE - 1; i > 0; i--) begin
      hb[i] = hb[i-1];
      hs[i] = hs[i-1];
    end
    hb[0]    = v ? base : -1;
    hs[0]    = step;
    in_valid = v;
    for (int j = 0; j < SIZE; j++) begin
      acc_in[j] = (hb[j] >= 0) ? ACC_WIDTH'(hb[j] + hs[j] * j) : 16'hBEEF;
    end
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    clear_hist();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_hist();
    for (int j = 0; j < SIZE; j++) acc_in[j] = '0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_level", 32'(fifo_level), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_last", 32'(out_last), 32'(0));
    chk_vec("rst_data", 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // Single vector {10,20,30,40}: visible only in cycle 4.
    out_ready = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      cyc(c == 0, 10, 10);
      chk("single_valid", 32'(out_valid), 32'(c == 4));
      if (c == 4) begin
        chk_vec("single_data", 10, 10);
        chk("single_last", 32'(out_last), 32'(0));
      end
      tick();
    end

    // Eight back-to-back vectors with free-flowing output.
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      cyc(c < 8, 100 * c, 1);
      chk("b2b_valid", 32'(out_valid), 32'(c >= 4 && c <= 11));
      chk("b2b_level", 32'(fifo_level), 32'(c >= 4 && c <= 11));
      if (c >= 4 && c <= 11) begin
        k = c - 4;
        chk_vec("b2b_data", 100 * k, 1);
        chk("b2b_last", 32'(out_last), 32'(k % 4 == 3));
      end
      tick();
    end

    // Fill under backpressure; the ninth vector is dropped.
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      cyc(c < 9, 100 * c, 1);
      chk("bp_level", 32'(fifo_level), 32'((c <= 3) ? 0 : ((c <= 11) ? c - 3 : 8)));
      chk("bp_ovf", 32'(overflow), 32'(c == 12));
      chk("bp_valid", 32'(out_valid), 32'(c >= 4));
      tick();
    end
    out_ready = 1'b1;
    for (int d = 0; d <= 9; d++) begin
      cyc(1'b0, 0, 0);
      chk("drain_ovf", 32'(overflow), 32'(1));
      chk("drain_level", 32'(fifo_level), 32'((d < 8) ? 8 - d : 0));
      chk("drain_valid", 32'(out_valid), 32'(d < 8));
      if (d < 8) begin
        chk_vec("drain_data", 100 * d, 1);
        chk("drain_last", 32'(out_last), 32'(d % 4 == 3));
      end
      tick();
    end

    // Asynchronous reset with 2 stored and 3 in flight, overflow previously set.
    out_ready = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      cyc(1'b1, 300 + 10 * c, 1);
      tick();
    end
    cyc(1'b0, 0, 0);
    chk("pre_rst_level", 32'(fifo_level), 32'(2));
    chk("pre_rst_ovf", 32'(overflow), 32'(1));
    reset    = 1'b1;
    in_valid = 1'b0;
    clear_hist();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_level", 32'(fifo_level), 32'(0));
    chk("mid_rst_ovf", 32'(overflow), 32'(0));
    chk("mid_rst_last", 32'(out_last), 32'(0));
    chk_vec("mid_rst_data", 0, 0);
    tick();
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      cyc(c == 0, 900, 1);
      chk("post_rst_valid", 32'(out_valid), 32'(c == 4));
      chk("post_rst_level", 32'(fifo_level), 32'(c == 4));
      if (c == 4) chk_vec("post_rst_data", 900, 1);
      tick();
    end

    // Full FIFO with a push and pop in the same cycle.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      out_ready = (c >= 11);
      cyc(c < 9, 100 * c, 1);
      if (c >= 11 && c <= 19) begin
        k = c - 11;
        chk("fpp_valid", 32'(out_valid), 32'(1));
        chk_vec("fpp_data", 100 * k, 1);
        chk("fpp_last", 32'(out_last), 32'(k % 4 == 3));
        chk("fpp_level", 32'(fifo_level), 32'((c == 11) ? 8 : 8 - (c - 12)));
        chk("fpp_ovf", 32'(overflow), 32'(0));
      end else if (c == 20) begin
        chk("fpp_end_valid", 32'(out_valid), 32'(0));
        chk("fpp_end_level", 32'(fifo_level), 32'(0));
        chk("fpp_end_ovf", 32'(overflow), 32'(0));
      end
      tick();
    end

    // Stall pattern 0,0,1 on each head: data and last held, frame advances only on pops.
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      out_ready = (c >= 4) && ((c - 4) % 3 == 2);
      cyc(c < 4, 500 + 10 * c, 1);
      if (c >= 4) begin
        k = (c - 4) / 3;
        if (k < 4) begin
          chk("stall_valid", 32'(out_valid), 32'(1));
          chk_vec("stall_data", 500 + 10 * k, 1);
          chk("stall_last", 32'(out_last), 32'(k == 3));
        end else begin
          chk("stall_end_valid", 32'(out_valid), 32'(0));
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
